// File: rtl/seizure_detector.sv
// Seizure onset/offset detector: adaptive EMA baseline, run-length onset/offset FSM.
// Optional SZ_EVENT_COUNT_EN adds a saturating 16-bit onset counter on event_count.
module seizure_detector #(
  parameter int IN_WIDTH    = 40,
  parameter int ALPHA_SHIFT = 4,
  parameter int THR_SHIFT   = 2,
  parameter int WARMUP_CNT  = 32,
  parameter int ONSET_CNT   = 8,
  parameter int OFFSET_CNT  = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] din,
  input  logic                       din_valid,
  output logic                       seizure,
  output logic                       onset_pulse,
  output logic                       offset_pulse,
  output logic [IN_WIDTH-1:0]        baseline,
  output logic [2:0]                 state
`ifdef SZ_EVENT_COUNT_EN
  ,
  output logic [15:0]                event_count
`endif
);

  typedef enum logic [2:0] {
    ST_WARMUP  = 3'd0,
    ST_NORMAL  = 3'd1,
    ST_PENDING = 3'd2,
    ST_SEIZURE = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int CW = IN_WIDTH + THR_SHIFT;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IN_WIDTH-1:0]   base_q, base_d;
  logic                  seizure_q, seizure_d;
  logic                  onset_q, onset_d;
  logic                  offset_q, offset_d;

  logic                  acc;
  logic [IN_WIDTH-1:0]   x;
  logic                  above;
  logic signed [IN_WIDTH:0] diff, step, ema_sum;
  logic [IN_WIDTH-1:0]   ema;
  logic                  ema_msb_unused;

  assign acc     = en & din_valid;
  assign x       = din[IN_WIDTH-1] ? '0 : $unsigned(din);
  // Widened compare so baseline << THR_SHIFT never overflows.
  assign above   = CW'(x) > (CW'(base_q) << THR_SHIFT);
  assign diff    = $signed({1'b0, x}) - $signed({1'b0, base_q});
  assign step    = diff >>> ALPHA_SHIFT;
  assign ema_sum = $signed({1'b0, base_q}) + step;
  assign ema     = ema_sum[IN_WIDTH-1:0];
  assign ema_msb_unused = ema_sum[IN_WIDTH];
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    onset_d  = 1'b0;
    offset_d = 1'b0;
    if (acc) begin
      unique case (state_q)
        ST_WARMUP: begin
          // Counter is zero only on the first sample after reset: seed directly.
          base_d = (cnt_q == '0) ? x : ema;
          cnt_d  = cnt_inc;
          if (cnt_inc == CNT_WIDTH'(WARMUP_CNT)) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end
        end
        ST_NORMAL: begin
          if (above) begin
            if (ONSET_CNT == 1) begin
              state_d = ST_SEIZURE;
              cnt_d   = '0;
              onset_d = 1'b1;
            end else begin
              state_d = ST_PENDING;
              cnt_d   = CNT_WIDTH'(1);
            end
          end else begin
            base_d = ema;
          end
        end
        ST_PENDING: begin
          if (above) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_WIDTH'(ONSET_CNT)) begin
              state_d = ST_SEIZURE;
              cnt_d   = '0;
              onset_d = 1'b1;
            end
          end else begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
            base_d  = ema;
          end
        end
        ST_SEIZURE: begin
          if (!above) begin
            if (OFFSET_CNT == 1) begin
              state_d  = ST_NORMAL;
              cnt_d    = '0;
              offset_d = 1'b1;
            end else begin
              state_d = ST_RECOVER;
              cnt_d   = CNT_WIDTH'(1);
            end
          end
        end
        ST_RECOVER: begin
          if (!above) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_WIDTH'(OFFSET_CNT)) begin
              state_d  = ST_NORMAL;
              cnt_d    = '0;
              offset_d = 1'b1;
            end
          end else begin
            state_d = ST_SEIZURE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_WARMUP;
          cnt_d   = '0;
        end
      endcase
    end
    seizure_d = (state_d == ST_SEIZURE) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_WARMUP;
      cnt_q     <= '0;
      base_q    <= '0;
      seizure_q <= 1'b0;
      onset_q   <= 1'b0;
      offset_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      seizure_q <= seizure_d;
      onset_q   <= onset_d;
      offset_q  <= offset_d;
    end
  end

`ifdef SZ_EVENT_COUNT_EN
  logic [15:0] ev_q, ev_d;

  always_comb begin
    ev_d = ev_q;
    if (onset_d && ev_q != 16'hFFFF) ev_d = ev_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ev_q <= '0;
    else      ev_q <= ev_d;
  end

  assign event_count = ev_q;
`endif

  assign seizure      = seizure_q;
  assign onset_pulse  = onset_q;
  assign offset_pulse = offset_q;
  assign baseline     = base_q;
  assign state        = state_q;

endmodule

// File: tb/tb_seizure_detector.sv
// Self-checking bench for seizure_detector: directed plan scenarios plus a
// randomized run against a run-length/EMA reference model.
module tb_seizure_detector;

  localparam int W = 40;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en = 1'b0;
  logic signed [W-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic                seizure, onset_pulse, offset_pulse;
  logic [W-1:0]        baseline;
  logic [2:0]          state;
`ifdef SZ_EVENT_COUNT_EN
  logic [15:0]         event_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase name, run length, baseline as plain integers.
  longint m_base;
  int     m_phase;   // 0 warmup,1 normal,2 pending,3 seizure,4 recover
  int     m_run;
  bit     m_on, m_off;
  int     m_ev;

  seizure_detector dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .seizure(seizure), .onset_pulse(onset_pulse), .offset_pulse(offset_pulse),
    .baseline(baseline), .state(state)
`ifdef SZ_EVENT_COUNT_EN
    , .event_count(event_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_base = 0; m_phase = 0; m_run = 0; m_on = 0; m_off = 0; m_ev = 0;
  endfunction

  function automatic void model_step(input bit acc, input longint d);
    longint x, nb;
    bit hi;
    m_on = 0; m_off = 0;
    if (!acc) return;
    x  = (d < 0) ? 0 : d;
    hi = x > m_base * 4;
    nb = m_base + ((x - m_base) >>> 4);
    case (m_phase)
      0: begin
        m_base = (m_run == 0) ? x : nb;
        m_run++;
        if (m_run == 32) begin m_phase = 1; m_run = 0; end
      end
      1: if (hi) begin m_phase = 2; m_run = 1; end else m_base = nb;
      2: if (hi) begin
           m_run++;
           if (m_run == 8) begin
             m_phase = 3; m_run = 0; m_on = 1;
             if (m_ev < 65535) m_ev++;
           end
         end else begin m_phase = 1; m_run = 0; m_base = nb; end
      3: if (!hi) begin m_phase = 4; m_run = 1; end
      default: if (!hi) begin
           m_run++;
           if (m_run == 16) begin m_phase = 1; m_run = 0; m_off = 1; end
         end else begin m_phase = 3; m_run = 0; end
    endcase
  endfunction

  // Drive one cycle; outputs are sampled by callers #1 after the edge.
  task automatic step(input bit e, input bit v, input longint d);
    longint dd;
    dd = d;
    en = e; din_valid = v; din = dd[W-1:0];
    @(posedge clk);
    model_step(e && v, d);
    #1;
  endtask

  task automatic apply_reset();
    rst = 0; en = 0; din_valid = 0;
    #3;
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (state !== 3'd0 || baseline !== '0 || seizure !== 1'b0 || onset_pulse !== 1'b0 || offset_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset: state=%0d base=%0d sz=%b on=%b off=%b, expected 0/0/0/0/0", state, baseline, seizure, onset_pulse, offset_pulse);
    end
  endtask

  task automatic test_warmup();
    bit sz_seen = 0;
    for (int i = 0; i < 32; i++) begin
      step(1, 1, 100);
      if (seizure) sz_seen = 1;
      if (i == 30) begin
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL warmup_still: state=%0d expected 0", state); end
      end
    end
    n_cmp++; if (state !== 3'd1 || baseline !== 40'd100) begin
      n_err++; $display("FAIL warmup_done: state=%0d base=%0d expected 1/100", state, baseline);
    end
    n_cmp++; if (sz_seen) begin n_err++; $display("FAIL warmup_seizure: seizure seen=1 expected 0"); end
  endtask

  task automatic test_onset();
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 500);
      if (i < 7) begin
        n_cmp++; if (seizure !== 1'b0 || onset_pulse !== 1'b0) begin
          n_err++; $display("FAIL onset_early[%0d]: sz=%b on=%b expected 0/0", i, seizure, onset_pulse);
        end
      end
    end
    n_cmp++; if (onset_pulse !== 1'b1 || seizure !== 1'b1 || state !== 3'd3 || baseline !== 40'd100) begin
      n_err++; $display("FAIL onset: on=%b sz=%b state=%0d base=%0d expected 1/1/3/100", onset_pulse, seizure, state, baseline);
    end
    step(1, 1, 500);
    n_cmp++; if (onset_pulse !== 1'b0 || seizure !== 1'b1) begin
      n_err++; $display("FAIL onset_pulse_width: on=%b sz=%b expected 0/1", onset_pulse, seizure);
    end
  endtask

  task automatic test_offset();
    for (int i = 0; i < 15; i++) step(1, 1, 50);
    n_cmp++; if (state !== 3'd4 || seizure !== 1'b1) begin
      n_err++; $display("FAIL recover_15: state=%0d sz=%b expected 4/1", state, seizure);
    end
    step(1, 1, 500);
    n_cmp++; if (state !== 3'd3 || seizure !== 1'b1 || offset_pulse !== 1'b0) begin
      n_err++; $display("FAIL recover_abort: state=%0d sz=%b off=%b expected 3/1/0", state, seizure, offset_pulse);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 50);
      if (i == 14) begin
        n_cmp++; if (seizure !== 1'b1 || offset_pulse !== 1'b0) begin
          n_err++; $display("FAIL offset_early: sz=%b off=%b expected 1/0", seizure, offset_pulse);
        end
      end
    end
    n_cmp++; if (offset_pulse !== 1'b1 || seizure !== 1'b0 || state !== 3'd1 || baseline !== 40'd100) begin
      n_err++; $display("FAIL offset: off=%b sz=%b state=%0d base=%0d expected 1/0/1/100", offset_pulse, seizure, state, baseline);
    end
    step(1, 0, 50);
    n_cmp++; if (offset_pulse !== 1'b0) begin n_err++; $display("FAIL offset_pulse_width: off=%b expected 0", offset_pulse); end
  endtask

  task automatic test_clamp();
    step(1, 1, -1000);
    n_cmp++; if (baseline !== 40'd93 || state !== 3'd1) begin
      n_err++; $display("FAIL clamp: base=%0d state=%0d expected 93/1", baseline, state);
    end
  endtask

  task automatic test_aborted();
    // Threshold is now 4*93 = 372; exact threshold is not above.
    step(1, 1, 372);
    n_cmp++; if (state !== 3'd1 || baseline !== 40'(m_base) || m_base != 93 + ((372 - 93) >>> 4)) begin
      n_err++; $display("FAIL equal_thr: state=%0d base=%0d expected 1/%0d", state, baseline, 93 + ((372 - 93) >>> 4));
    end
    for (int i = 0; i < 7; i++) step(1, 1, 5000);
    n_cmp++; if (state !== 3'd2 || seizure !== 1'b0) begin
      n_err++; $display("FAIL pending7: state=%0d sz=%b expected 2/0", state, seizure);
    end
    step(1, 1, m_base * 4);
    n_cmp++; if (state !== 3'd1 || seizure !== 1'b0 || onset_pulse !== 1'b0 || baseline !== 40'(m_base)) begin
      n_err++; $display("FAIL aborted: state=%0d sz=%b base=%0d expected 1/0/%0d", state, seizure, baseline, m_base);
    end
  endtask

  task automatic test_gaps();
    int acc_n = 0;
    while (acc_n < 8) begin
      step(1, 1, 100000);
      acc_n++;
      if (acc_n < 8) begin
        step(0, 1, 100000);
        step(1, 0, 100000);
        n_cmp++; if (onset_pulse !== 1'b0 || seizure !== 1'b0) begin
          n_err++; $display("FAIL gap_onset[%0d]: on=%b sz=%b expected 0/0", acc_n, onset_pulse, seizure);
        end
      end
    end
    n_cmp++; if (onset_pulse !== 1'b1 || seizure !== 1'b1) begin
      n_err++; $display("FAIL gap_onset: on=%b sz=%b expected 1/1", onset_pulse, seizure);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 100000);
    #2;
    rst = 0;
    #1;
    n_cmp++; if (seizure !== 1'b0 || baseline !== '0 || state !== 3'd0) begin
      n_err++; $display("FAIL async_reset: sz=%b base=%0d state=%0d expected 0/0/0", seizure, baseline, state);
    end
`ifdef SZ_EVENT_COUNT_EN
    n_cmp++; if (event_count !== 16'd0) begin n_err++; $display("FAIL ev_reset: got %0d expected 0", event_count); end
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

`ifdef SZ_EVENT_COUNT_EN
  task automatic test_event_count();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) step(1, 1, 100);
      for (int i = 0; i < 8; i++) step(1, 1, 500);
      apply_reset_keep_ev(k);
    end
    n_cmp++; if (event_count !== 16'd2) begin n_err++; $display("FAIL ev_two: got %0d expected 2", event_count); end
  endtask

  // Between onsets, return to NORMAL via offset rather than reset so the count survives.
  task automatic apply_reset_keep_ev(input int k);
    for (int i = 0; i < 16; i++) step(1, 1, 50);
    for (int i = 0; i < 32 && k == 0; i++) step(0, 0, 0);
  endtask
`endif

  task automatic test_random();
    int mode = 0;
    longint d;
    for (int c = 0; c < 1500; c++) begin
      if (c % 24 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0: d = longint'($urandom_range(0, 300));
        1: d = m_base * 4 + longint'($urandom_range(0, 2000));
        default: d = longint'($urandom_range(0, 600)) - 200;
      endcase
      if ($urandom_range(0, 9) == 0) d = m_base * 4;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, d);
      n_cmp++; if (state !== 3'(m_phase) || baseline !== 40'(m_base) || seizure !== (m_phase == 3 || m_phase == 4)
                   || onset_pulse !== m_on || offset_pulse !== m_off) begin
        n_err++; $display("FAIL random[%0d]: state=%0d base=%0d sz=%b on=%b off=%b expected %0d/%0d/%b/%b/%b",
                          c, state, baseline, seizure, onset_pulse, offset_pulse, m_phase, m_base,
                          (m_phase == 3 || m_phase == 4), m_on, m_off);
      end
    end
`ifdef SZ_EVENT_COUNT_EN
    n_cmp++; if (event_count !== 16'(m_ev)) begin n_err++; $display("FAIL ev_random: got %0d expected %0d", event_count, m_ev); end
`endif
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_onset();
    test_offset();
    test_clamp();
    test_aborted();
    test_gaps();
    test_reset_mid();
`ifdef SZ_EVENT_COUNT_EN
    test_event_count();
    apply_reset();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
